// File: rtl/panda_ram_arbiter.sv
// panda_ram_arbiter
//
// Shares one single-port panda_ram between the core's instruction-fetch port
// (read-only) and its load/store port (read/write with byte enables). At most one
// request is granted per cycle. Grants are combinational, so an uncontended request
// is accepted in the cycle it is raised. The RAM returns read data one cycle after
// the strobe. A registered response selector routes that data back as rvalid on the
// port that was granted.
//
// Arbitration:
//   default             fixed priority. Data wins on conflict. A 4-bit wait counter
//                       forces an instruction grant after MaxWait stalled cycles.
//   PANDA_ARB_RR_EN     round-robin on conflict, using a 1-bit last-granted register.
//                       The wait counter is not built in this mode.
//
// Parameters:
//   DataWidth  RAM word width in bits; must be a multiple of 8.
//   Depth      RAM depth in words.
//   MaxWait    fixed-priority starvation bound, 1..15.
//
// Ports:
//   clk_i, rst_i                  clock; synchronous active-high reset
//   instr_req_i / instr_addr_i    instruction read request
//   instr_gnt_o                   instruction request accepted this cycle
//   instr_rvalid_o/instr_rdata_o  instruction read response
//   data_req_i / data_we_i /      data request; data_we_i = 0 means read
//   data_addr_i / data_wdata_i
//   data_gnt_o                    data request accepted this cycle
//   data_rvalid_o/data_rdata_o    data response (read data, or write ack)
//   ram_ce_o / ram_we_o /         RAM strobe, byte enables, address, write data
//   ram_addr_o / ram_wdata_o
//   ram_rdata_i                   RAM read data, valid one cycle after a read strobe

module panda_ram_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 64,
    parameter int unsigned MaxWait   = 4,
    localparam int unsigned AddrWidth = $clog2(Depth),
    localparam int unsigned BeWidth   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 instr_req_i,
    input  logic [AddrWidth-1:0] instr_addr_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    output logic [DataWidth-1:0] instr_rdata_o,

    input  logic                 data_req_i,
    input  logic [BeWidth-1:0]   data_we_i,
    input  logic [AddrWidth-1:0] data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,

    output logic                 ram_ce_o,
    output logic [BeWidth-1:0]   ram_we_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [DataWidth-1:0] ram_wdata_o,
    input  logic [DataWidth-1:0] ram_rdata_i
);

    // Resolved grants for this cycle.
    logic instr_gnt;
    logic data_gnt;

    // High when the instruction port should win a conflict this cycle.
    logic instr_prio;

    // Response tracking: a grant in cycle N yields rvalid in cycle N+1.
    logic resp_valid_q;
    logic resp_sel_q;   // 1: response belongs to the instruction port

`ifdef PANDA_ARB_RR_EN

    // 1: the instruction port was granted last; 0: the data port was.
    logic last_gnt_q;

    assign instr_prio = ~last_gnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Reset to "instr" so the data port wins the first conflict.
            last_gnt_q <= 1'b1;
        end else if (instr_gnt) begin
            last_gnt_q <= 1'b1;
        end else if (data_gnt) begin
            last_gnt_q <= 1'b0;
        end
    end

`else

    localparam logic [3:0] MaxWaitCnt = 4'(MaxWait);

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    assign instr_prio = (wait_cnt_q == MaxWaitCnt);

    // Count consecutive stalled cycles of a pending instruction request. A dropped
    // request clears the count, so a cancelled fetch leaves no residue.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!instr_req_i || instr_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != MaxWaitCnt) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

`endif

    // Grant resolution. Reset masks both grants so nothing reaches the RAM.
    always_comb begin
        instr_gnt = 1'b0;
        data_gnt  = 1'b0;
        if (!rst_i) begin
            if (data_req_i && !(instr_req_i && instr_prio)) begin
                data_gnt = 1'b1;
            end else if (instr_req_i) begin
                instr_gnt = 1'b1;
            end
        end
    end

    assign instr_gnt_o = instr_gnt;
    assign data_gnt_o  = data_gnt;

    // RAM port mux. Idle cycles park the address and write data at zero.
    always_comb begin
        ram_ce_o    = instr_gnt | data_gnt;
        ram_we_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (data_gnt) begin
            ram_we_o    = data_we_i;
            ram_addr_o  = data_addr_i;
            ram_wdata_o = data_wdata_i;
        end else if (instr_gnt) begin
            ram_addr_o  = instr_addr_i;
        end
    end

    // A response registered just before reset rises is still presented in the
    // reset cycle; it clears on the following edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_sel_q   <= 1'b0;
        end else begin
            resp_valid_q <= instr_gnt | data_gnt;
            if (instr_gnt | data_gnt) begin
                resp_sel_q <= instr_gnt;
            end
        end
    end

    assign instr_rvalid_o = resp_valid_q & resp_sel_q;
    assign data_rvalid_o  = resp_valid_q & ~resp_sel_q;
    assign instr_rdata_o  = ram_rdata_i;
    assign data_rdata_o   = ram_rdata_i;

    // Grants must be mutually exclusive.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(instr_gnt && data_gnt))
                else $error("panda_ram_arbiter: both ports granted");
        end
    end

endmodule

// File: doc/panda_ram_arbiter.md
# panda_ram_arbiter

Two-port arbiter sharing one single-port `panda_ram` instance between the core's instruction-fetch port (read-only) and its load/store port (read/write with byte enables). It sits between the core and the RAM. Each cycle it grants at most one request, drives the RAM port, and routes the one-cycle-latency read data back to the granted requester with a registered response valid. A starvation counter bounds instruction-fetch wait under fixed priority; round-robin is a compile-time option.

## Interface
- `DataWidth`, 32: RAM word width in bits; must be a multiple of 8.
- `Depth`, 64: RAM depth in words; `AddrWidth = $clog2(Depth)`.
- `MaxWait`, 4: fixed-priority mode only; consecutive stalled cycles of a pending instruction request before it is forced a grant. Range 1..15.

Ports:
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset; one clock, synchronous, active-high.
- `instr_req_i` in 1: instruction read request.
- `instr_addr_i` in AddrWidth: instruction word address.
- `instr_gnt_o` out 1: request accepted this cycle.
- `instr_rvalid_o` out 1: `instr_rdata_o` valid.
- `instr_rdata_o` out DataWidth: read data.
- `data_req_i` in 1: data request.
- `data_we_i` in DataWidth/8: byte write enables; all-zero means read.
- `data_addr_i` in AddrWidth: data word address.
- `data_wdata_i` in DataWidth: write data.
- `data_gnt_o` out 1: request accepted this cycle.
- `data_rvalid_o` out 1: response valid, for a read or a write ack.
- `data_rdata_o` out DataWidth: read data. Undefined on a write ack.
- `ram_ce_o` out 1: RAM chip enable.
- `ram_we_o` out DataWidth/8: RAM byte write enables.
- `ram_addr_o` out AddrWidth: RAM address.
- `ram_wdata_o` out DataWidth: RAM write data.
- `ram_rdata_i` in DataWidth: RAM `data_o`; valid one cycle after a strobed read.

## Operation
- Grants are combinational from the requests, the priority state, and `rst_i`.
- At most one of `instr_gnt_o` and `data_gnt_o` is high in any cycle.
- `ram_ce_o = instr_gnt_o | data_gnt_o`.
- RAM port muxing:
  - On a data grant, the RAM port carries the data port's `we`, `addr` and `wdata`.
  - On an instruction grant, `ram_we_o` = 0 and `ram_addr_o` = `instr_addr_i`.
  - Otherwise `ram_we_o` = 0 and `ram_addr_o`/`ram_wdata_o` = 0.
- Request protocol:
  - A requester holds `req` and all request fields stable until it sees `gnt`.
  - Dropping `req` before `gnt` is allowed and cancels the request without side effect.
- Fixed priority (default):
  - The data port wins on conflict.
  - `wait_cnt` (4 bits) increments each cycle in which `instr_req_i` is high and not granted.
  - `wait_cnt` clears on an instruction grant, or when `instr_req_i` is low.
  - When `wait_cnt` = `MaxWait` and both ports request, the instruction port wins.
- Response path:
  - A grant in cycle N registers `resp_sel` (instr/data) and `resp_valid`.
  - In cycle N+1 the matching `*_rvalid_o` is high.
  - Both `rdata` outputs are driven combinationally from `ram_rdata_i`; only the selected port's `rvalid` is asserted.
  - A write grant produces `data_rvalid_o` in N+1, as an ack.
- Back-to-back: a new grant may issue in N+1 while the response for N is being returned. Throughput is one access per cycle.

## Timing
- Request to grant: 0 cycles when uncontended. Grant to rvalid: exactly 1 cycle.
- Reset values: `resp_valid` = 0, `wait_cnt` = 0, round-robin pointer = data-preferred, so both `rvalid` outputs are 0.
- While `rst_i` is high, both grants and `ram_ce_o` are forced low combinationally.
- Reset mid-operation:
  - A response registered before `rst_i` rises is still presented in its cycle.
  - Nothing granted during reset; the first grant is possible in the cycle after `rst_i` falls.
- Same-address read after write:
  - Write granted in N, read granted in N+1.
  - The read returns the new data in N+2 (RAM write-first is not required).
- `wait_cnt` saturates at `MaxWait` and never wraps.

## Configuration
- Macro: `PANDA_ARB_RR_EN`.
- Defined:
  - Round-robin arbitration replaces fixed priority. A 1-bit `last_gnt` register names the port granted last.
  - On conflict, the port that was not granted last wins.
  - `last_gnt` updates only on a grant; its reset value is "instr", so data wins the first conflict.
  - `wait_cnt` and `MaxWait` logic are not built.
- Undefined: fixed priority with starvation counter, as in Operation.

## Test plan
- Reset, then instr read at addr 3, RAM word 3 = 0x00000003:
  - `instr_gnt_o` high in the request cycle.
  - `instr_rvalid_o` high one cycle later with `instr_rdata_o` = 0x00000003.
  - `data_rvalid_o` low throughout.
- Data write addr 40, `we` = 4'b0011, wdata 0xABCDEF89, over word 0x11223344; then data read addr 40:
  - Write ack `data_rvalid_o` one cycle after the write grant.
  - Read returns 0x1122EF89.
- Fixed priority, `MaxWait` = 4, both ports requesting continuously:
  - Grant sequence D,D,D,D,I,D,D,D,D,I…
  - Every instruction response arrives the cycle after its grant.
- With `PANDA_ARB_RR_EN`, both ports requesting continuously: grants alternate D,I,D,I starting with D after reset.
- Assert `rst_i` in the cycle after a data read grant:
  - `data_rvalid_o` still high that cycle.
  - No grant while `rst_i` is high.
  - A request held across reset is granted in the first cycle after `rst_i` falls.
- Instr req held 2 cycles then dropped without grant, while data is granted:
  - No instruction `rvalid`.
  - `wait_cnt` returns to 0.
  - RAM sees only the data accesses.
